// File: rtl/r3_fft_pkg.sv
// Shared definitions for the radix-3 FFT pipeline stages.
//   R3_W    : default component width (two's complement re/img)
//   cplx_t  : complex sample {re, img}
//   phase_e : which third of a frame the current sample belongs to
//   idx_w() : width of an index into a D-deep bank (never below 1)
//   cnt_w() : width of a sample counter spanning one 3*D frame
package r3_fft_pkg;

    localparam int R3_W = 32;

    typedef struct packed {
        logic [R3_W-1:0] re;
        logic [R3_W-1:0] img;
    } cplx_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    function automatic int idx_w(input int d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(3 * d);
    endfunction

endpackage

// File: rtl/cplx_bank.sv
// D-deep storage for complex samples, packed as {re, img}.
//   clk   : write clock
//   we    : write enable
//   waddr : write index, 0..D-1
//   wdata : sample to store
//   raddr : read index, 0..D-1
//   rdata : combinational read of mem[raddr]
// No reset: contents are only read after the same frame wrote them.
module cplx_bank
    import r3_fft_pkg::*;
#(
    parameter int W = R3_W,
    parameter int D = 9
) (
    input  logic                clk,
    input  logic                we,
    input  logic [idx_w(D)-1:0] waddr,
    input  logic [2*W-1:0]      wdata,
    input  logic [idx_w(D)-1:0] raddr,
    output logic [2*W-1:0]      rdata
);

    logic [2*W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/r3_input_commutator.sv
// Radix-3 input commutator. Takes one complex sample per valid cycle in
// natural order; for each frame of 3*D samples it stores the first two
// thirds in bank0/bank1 and, during the last third, emits the triplet
// x[k], x[k+D], x[k+2D] one cycle after each input.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid          : sample present
//   in_re, in_img     : input sample
//   out_valid         : triplet valid (registered)
//   out_k             : butterfly index k
//   out0/out1/out2_*  : x[k], x[k+D], x[k+2D]; hold when out_valid = 0
module r3_input_commutator
    import r3_fft_pkg::*;
#(
    parameter int W = R3_W,
    parameter int D = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [W-1:0]        in_re,
    input  logic [W-1:0]        in_img,
    output logic                out_valid,
    output logic [idx_w(D)-1:0] out_k,
    output logic [W-1:0]        out0_re,
    output logic [W-1:0]        out0_img,
    output logic [W-1:0]        out1_re,
    output logic [W-1:0]        out1_img,
    output logic [W-1:0]        out2_re,
    output logic [W-1:0]        out2_img
);

    localparam int CW = cnt_w(D);
    localparam int IW = idx_w(D);

    localparam logic [CW-1:0] ONE_D = CW'(D);
    localparam logic [CW-1:0] TWO_D = CW'(2 * D);
    localparam logic [CW-1:0] LAST  = CW'(3 * D - 1);

    logic [CW-1:0]  cnt;
    phase_e         phase;
    logic [IW-1:0]  j;
    logic           we0;
    logic           we1;
    logic [2*W-1:0] sample;
    logic [2*W-1:0] rd0;
    logic [2*W-1:0] rd1;

    // Phase and local index from range compares; avoids a mod-D divider.
    always_comb begin
        phase = PH0;
        j     = IW'(cnt);
        if (cnt >= TWO_D) begin
            phase = PH2;
            j     = IW'(cnt - TWO_D);
        end else if (cnt >= ONE_D) begin
            phase = PH1;
            j     = IW'(cnt - ONE_D);
        end
    end

    assign sample = {in_re, in_img};
    // Gate writes with rst_n so a sample presented during reset never lands.
    assign we0    = rst_n && in_valid && (phase == PH0);
    assign we1    = rst_n && in_valid && (phase == PH1);

    cplx_bank #(.W(W), .D(D)) bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (j),
        .wdata (sample),
        .raddr (j),
        .rdata (rd0)
    );

    cplx_bank #(.W(W), .D(D)) bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (j),
        .wdata (sample),
        .raddr (j),
        .rdata (rd1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_k     <= '0;
            out0_re   <= '0;
            out0_img  <= '0;
            out1_re   <= '0;
            out1_img  <= '0;
            out2_re   <= '0;
            out2_img  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                if (phase == PH2) begin
                    out_valid <= 1'b1;
                    out_k     <= j;
                    out0_re   <= rd0[2*W-1:W];
                    out0_img  <= rd0[W-1:0];
                    out1_re   <= rd1[2*W-1:W];
                    out1_img  <= rd1[W-1:0];
                    out2_re   <= in_re;
                    out2_img  <= in_img;
                end
            end
        end
    end

endmodule

// File: tb/tb_r3_input_commutator.sv
module tb_r3_input_commutator;

    localparam int W = 32;
    localparam int D = 9;
    localparam int N = 3 * D;

    typedef struct packed {
        logic [3:0]   k;
        logic [W-1:0] r0, i0, r1, i1, r2, i2;
    } trip_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_re, in_img;
    logic         out_valid;
    logic [3:0]   out_k;
    logic [W-1:0] out0_re, out0_img, out1_re, out1_img, out2_re, out2_img;

    r3_input_commutator #(.W(W), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_img    (in_img),
        .out_valid (out_valid),
        .out_k     (out_k),
        .out0_re   (out0_re),
        .out0_img  (out0_img),
        .out1_re   (out1_re),
        .out1_img  (out1_img),
        .out2_re   (out2_re),
        .out2_img  (out2_img)
    );

    always #5 clk = ~clk;

    int     n_vec  = 0;
    int     n_miss = 0;
    int     n_out  = 0;
    int     m_cnt  = 0;
    logic   exp_vld = 1'b0;
    logic   mon_en  = 1'b0;
    trip_t  cur_exp = '0;
    trip_t  sb [$];
    logic [2*W-1:0] frame_s [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model tracks its own frame
    // position and pushes the expected triplet on every last-third input.
    task automatic step(input logic rst, input logic v, input int val);
        trip_t t;
        logic  nv;
        int    jj;
        rst_n    = rst;
        in_valid = v;
        in_re    = W'(val);
        in_img   = W'(-val);
        nv = 1'b0;
        if (!rst) begin
            m_cnt = 0;
        end else if (v) begin
            frame_s[m_cnt] = {W'(val), W'(-val)};
            if (m_cnt >= 2 * D) begin
                jj = m_cnt - 2 * D;
                t.k  = 4'(jj);
                {t.r0, t.i0} = frame_s[jj];
                {t.r1, t.i1} = frame_s[jj + D];
                {t.r2, t.i2} = frame_s[m_cnt];
                sb.push_back(t);
                nv = 1'b1;
            end
            m_cnt = (m_cnt == N - 1) ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        #1;
        exp_vld = nv;
        if (!rst) begin
            cur_exp = '0;
            sb.delete();
        end
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(exp_vld));
            if (out_valid) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    cur_exp = sb.pop_front();
                end
            end
            chk("out_k", 64'(out_k),        64'(cur_exp.k));
            chk("out0",  {out0_re, out0_img}, {cur_exp.r0, cur_exp.i0});
            chk("out1",  {out1_re, out1_img}, {cur_exp.r1, cur_exp.i1});
            chk("out2",  {out2_re, out2_img}, {cur_exp.r2, cur_exp.i2});
        end
    end

    task automatic frame(input int base, input int idle_pct);
        for (int n = 0; n < N; n++) begin
            while ($urandom_range(99) < idle_pct) step(1'b1, 1'b0, 32'hdead);
            step(1'b1, 1'b1, base + n);
        end
    endtask

    task automatic count_check(input string tag, input int exp);
        step(1'b1, 1'b0, 0);
        chk(tag, 64'(n_out), 64'(exp));
        n_out = 0;
    endtask

    initial begin
        // in_valid held high during reset must be ignored; outputs all zero.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 500 + i);
        n_out = 0;

        // Single continuous frame.
        frame(0, 0);
        count_check("cnt_frame1", D);

        // Three back-to-back frames, values offset by 100*f.
        for (int f = 0; f < 3; f++) frame(100 * f, 0);
        count_check("cnt_b2b", 3 * D);

        // Two frames with roughly 40% idle cycles.
        for (int f = 0; f < 2; f++) frame(1000 + 100 * f, 40);
        count_check("cnt_gaps", 2 * D);

        // Hold: outputs must stay at the k=D-1 triplet across idle cycles.
        frame(2000, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
        chk("hold_k", 64'(out_k), 64'(D - 1));
        n_out = 0;

        // Reset mid-frame after input 14, then a full fresh frame.
        for (int n = 0; n < 15; n++) step(1'b1, 1'b1, 3000 + n);
        step(1'b0, 1'b0, 0);
        chk("rst_out0", {out0_re, out0_img}, 64'(0));
        frame(4000, 0);
        count_check("cnt_rstmid", D);

        step(1'b1, 1'b0, 0);
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
